// File: rtl/tile_scroll_ctrl.sv
// rtl/tile_scroll_ctrl.sv - side-scrolling tilemap refill engine with host port sharing
//
// Keeps a 32-column x 15-row tilemap ring filled from a level store while the
// scroll offset advances, and shares the tilemap write port with a host.
//
// Ports:
//   mem_clk, mem_reset_n       clock, synchronous active-low reset
//   start, stop                level begin / return-to-idle pulses
//   frame_tick, speed[4:0]     per-frame advance pulse, pixels per frame
//   level_addr[13:0]           {level_col[9:0], row[3:0]} level read address
//   level_data[7:0]            tile number, valid one cycle after level_addr
//   tm_address, tm_we,
//   tm_din, tm_dout            tilemap port (engine or granted host)
//   host_req, host_we,
//   host_addr, host_din        host tilemap access request
//   host_ack, host_rdata       one-cycle grant, captured read data
//   scroll_offset[9:0]         pixel scroll position, modulo 1024
//   running, busy              engine active / engine filling the ring
//   level_end, overrun         sticky: past end of level / frame tick dropped

module tile_scroll_ctrl #(
  parameter int LEVEL_COLS = 512
) (
  input  logic        mem_clk,
  input  logic        mem_reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        frame_tick,
  input  logic [4:0]  speed,
  output logic [13:0] level_addr,
  input  logic [7:0]  level_data,
  output logic [13:0] tm_address,
  output logic        tm_we,
  output logic [7:0]  tm_din,
  input  logic [7:0]  tm_dout,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [13:0] host_addr,
  input  logic [7:0]  host_din,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic [9:0]  scroll_offset,
  output logic        running,
  output logic        busy,
  output logic        level_end,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRELOAD,
    S_RUN,
    S_REFILL
  } state_t;

  localparam logic [3:0]  LAST_ROW     = 4'd14;
  localparam logic [4:0]  LAST_COL     = 5'd31;
  localparam logic [10:0] LEVEL_COLS_W = 11'(LEVEL_COLS);

  state_t      state_q, state_d;
  logic [9:0]  offset_q, offset_d;
  logic [10:0] next_col_q, next_col_d;
  logic        pend_q, pend_d;
  logic        level_end_q, level_end_d;
  logic        overrun_q, overrun_d;

  // Read-issue stage: address presented to the level store this cycle.
  logic        iss_vld_q, iss_vld_d;
  logic        iss_zero_q, iss_zero_d;
  logic [3:0]  iss_row_q, iss_row_d;
  logic [4:0]  iss_col_q, iss_col_d;
  logic [9:0]  iss_lcol_q, iss_lcol_d;

  // Write stage: one cycle behind issue, so level_data lines up with it.
  logic        wr_vld_q, wr_vld_d;
  logic        wr_zero_q, wr_zero_d;
  logic [3:0]  wr_row_q, wr_row_d;
  logic [4:0]  wr_col_q, wr_col_d;

  logic        ack_q, ack_d;
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  host_rdata_q, host_rdata_d;

  logic        eff_tick;
  logic [9:0]  sum_off;
  logic        crossing;
  logic        col_past_end;
  logic        engine_quiet;
  logic        host_gnt;

  always_comb begin
    eff_tick     = frame_tick | pend_q;
    sum_off      = offset_q + {5'b0, speed};
    crossing     = (sum_off[9:5] != offset_q[9:5]);
    col_past_end = (next_col_q >= LEVEL_COLS_W);
    // A tick (new or pending) in RUN may start a refill, so the host waits.
    engine_quiet = (state_q == S_IDLE) || ((state_q == S_RUN) && !eff_tick);
    // ack_q forces a gap so a held request is granted once per pulse.
    host_gnt     = mem_reset_n && host_req && !ack_q && engine_quiet;
  end

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    next_col_d   = next_col_q;
    pend_d       = pend_q;
    level_end_d  = level_end_q;
    overrun_d    = overrun_q;
    iss_vld_d    = iss_vld_q;
    iss_zero_d   = iss_zero_q;
    iss_row_d    = iss_row_q;
    iss_col_d    = iss_col_q;
    iss_lcol_d   = iss_lcol_q;
    wr_vld_d     = 1'b0;
    wr_zero_d    = wr_zero_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    ack_d        = host_gnt;
    rd_pend_d    = host_gnt & ~host_we;
    host_rdata_d = rd_pend_q ? tm_dout : host_rdata_q;

    // Issue stage walks rows 0..14; PRELOAD continues through all 32 columns,
    // REFILL stops after its single column.
    if (iss_vld_q) begin
      wr_vld_d  = 1'b1;
      wr_zero_d = iss_zero_q;
      wr_row_d  = iss_row_q;
      wr_col_d  = iss_col_q;
      if (iss_row_q == LAST_ROW) begin
        iss_row_d = 4'd0;
        if ((state_q == S_PRELOAD) && (iss_col_q != LAST_COL)) begin
          iss_col_d  = iss_col_q + 5'd1;
          iss_lcol_d = iss_lcol_q + 10'd1;
        end else begin
          iss_vld_d = 1'b0;
        end
      end else begin
        iss_row_d = iss_row_q + 4'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_PRELOAD;
          offset_d    = 10'd0;
          next_col_d  = 11'd0;
          level_end_d = 1'b0;
          overrun_d   = 1'b0;
          pend_d      = 1'b0;
          iss_vld_d   = 1'b1;
          iss_zero_d  = 1'b0;
          iss_row_d   = 4'd0;
          iss_col_d   = 5'd0;
          iss_lcol_d  = 10'd0;
        end
      end

      S_PRELOAD: begin
        if (frame_tick) begin
          if (pend_q) overrun_d = 1'b1;
          else        pend_d    = 1'b1;
        end
        // Last write of the column is in flight and nothing more to issue.
        if (!iss_vld_q && wr_vld_q) begin
          state_d    = S_RUN;
          next_col_d = 11'd32;
        end
      end

      S_RUN: begin
        if (eff_tick) begin
          offset_d = sum_off;
          // A fresh tick landing on the pending one's cycle stays pending.
          pend_d   = frame_tick & pend_q;
          if (crossing) begin
            state_d    = S_REFILL;
            iss_vld_d  = 1'b1;
            iss_row_d  = 4'd0;
            // Column just scrolled fully off the left edge gets reused.
            iss_col_d  = sum_off[9:5] - 5'd1;
            iss_lcol_d = next_col_q[9:0];
            iss_zero_d = col_past_end;
            if (col_past_end) level_end_d = 1'b1;
          end
        end
      end

      S_REFILL: begin
        if (frame_tick) begin
          if (pend_q) overrun_d = 1'b1;
          else        pend_d    = 1'b1;
        end
        if (!iss_vld_q && wr_vld_q) begin
          state_d = S_RUN;
          // Saturate once past the level so next_col never wraps into data.
          if (!col_past_end) next_col_d = next_col_q + 11'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // stop overrides everything (including a same-cycle start) and freezes
    // the level position and sticky flags as they were.
    if (stop) begin
      state_d     = S_IDLE;
      pend_d      = 1'b0;
      iss_vld_d   = 1'b0;
      wr_vld_d    = 1'b0;
      offset_d    = offset_q;
      next_col_d  = next_col_q;
      level_end_d = level_end_q;
      overrun_d   = overrun_q;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (!mem_reset_n) begin
      state_q      <= S_IDLE;
      offset_q     <= 10'd0;
      next_col_q   <= 11'd0;
      pend_q       <= 1'b0;
      level_end_q  <= 1'b0;
      overrun_q    <= 1'b0;
      iss_vld_q    <= 1'b0;
      iss_zero_q   <= 1'b0;
      iss_row_q    <= 4'd0;
      iss_col_q    <= 5'd0;
      iss_lcol_q   <= 10'd0;
      wr_vld_q     <= 1'b0;
      wr_zero_q    <= 1'b0;
      wr_row_q     <= 4'd0;
      wr_col_q     <= 5'd0;
      ack_q        <= 1'b0;
      rd_pend_q    <= 1'b0;
      host_rdata_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      next_col_q   <= next_col_d;
      pend_q       <= pend_d;
      level_end_q  <= level_end_d;
      overrun_q    <= overrun_d;
      iss_vld_q    <= iss_vld_d;
      iss_zero_q   <= iss_zero_d;
      iss_row_q    <= iss_row_d;
      iss_col_q    <= iss_col_d;
      iss_lcol_q   <= iss_lcol_d;
      wr_vld_q     <= wr_vld_d;
      wr_zero_q    <= wr_zero_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      ack_q        <= ack_d;
      rd_pend_q    <= rd_pend_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Engine writes only happen in PRELOAD/REFILL and host grants only in
  // IDLE/RUN, so the two never meet on the tilemap port.
  always_comb begin
    level_addr = (iss_vld_q && !iss_zero_q) ? {iss_lcol_q, iss_row_q} : 14'd0;
    tm_we      = wr_vld_q | (host_gnt & host_we);
    tm_address = 14'd0;
    tm_din     = 8'd0;
    if (wr_vld_q) begin
      tm_address = {5'b0, wr_row_q, wr_col_q};
      tm_din     = wr_zero_q ? 8'h00 : level_data;
    end else if (host_gnt) begin
      tm_address = host_addr;
      tm_din     = host_we ? host_din : 8'd0;
    end
  end

  assign host_ack      = host_gnt;
  assign host_rdata    = host_rdata_q;
  assign scroll_offset = offset_q;
  assign running       = (state_q != S_IDLE);
  assign busy          = (state_q == S_PRELOAD) || (state_q == S_REFILL);
  assign level_end     = level_end_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_tile_scroll_ctrl.sv
// tb/tb_tile_scroll_ctrl.sv - scoreboard bench for tile_scroll_ctrl

module tb_tile_scroll_ctrl;

  localparam int LEVEL_COLS = 34;

  logic        mem_clk = 1'b0;
  logic        mem_reset_n;
  logic        start, stop, frame_tick;
  logic [4:0]  speed;
  logic [13:0] level_addr;
  logic [7:0]  level_data;
  logic [13:0] tm_address;
  logic        tm_we;
  logic [7:0]  tm_din;
  logic [7:0]  tm_dout;
  logic        host_req, host_we;
  logic [13:0] host_addr;
  logic [7:0]  host_din;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [9:0]  scroll_offset;
  logic        running, busy, level_end, overrun;

  tile_scroll_ctrl #(.LEVEL_COLS(LEVEL_COLS)) dut (
    .mem_clk(mem_clk), .mem_reset_n(mem_reset_n),
    .start(start), .stop(stop), .frame_tick(frame_tick), .speed(speed),
    .level_addr(level_addr), .level_data(level_data),
    .tm_address(tm_address), .tm_we(tm_we), .tm_din(tm_din), .tm_dout(tm_dout),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .scroll_offset(scroll_offset), .running(running), .busy(busy),
    .level_end(level_end), .overrun(overrun)
  );

  always #5 mem_clk = ~mem_clk;

  logic [7:0]  level_mem [0:16383];
  logic [7:0]  tm_mem    [0:16383];
  logic [7:0]  tm_model  [0:16383];
  logic [21:0] exp_q [$];
  logic [21:0] exp_e;
  logic [21:0] last_wr;
  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  int m_off, m_next;
  bit m_level_end;

  always @(posedge mem_clk) begin
    level_data <= level_mem[level_addr];
    tm_dout    <= tm_mem[tm_address];
    if (tm_we) tm_mem[tm_address] <= tm_din;
  end

  // Monitor: every tilemap write must be the next one the model predicted.
  always @(negedge mem_clk) begin
    if (tm_we === 1'b1) begin
      wr_count++;
      last_wr = {tm_address, tm_din};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tm_write: got addr %h data %h, expected no write", tm_address, tm_din);
      end else begin
        exp_e = exp_q.pop_front();
        if ({tm_address, tm_din} !== exp_e) begin
          n_fail++;
          $display("FAIL tm_write: got addr %h data %h, expected addr %h data %h",
                   tm_address, tm_din, exp_e[21:8], exp_e[7:0]);
        end
      end
    end
    if (host_ack === 1'b1) begin
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL host_ack_while_busy: got busy %b, expected 0", busy);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_write(input int addr, input logic [7:0] d);
    logic [13:0] a;
    a = 14'(addr);
    exp_q.push_back({a, d});
    tm_model[a] = d;
  endfunction

  function automatic void model_start();
    m_off = 0;
    m_next = 32;
    m_level_end = 0;
  endfunction

  // Ring (row r, column c) holds level column c, row r; emitted column by column.
  function automatic void push_preload(input int limit);
    int k;
    k = 0;
    for (int c = 0; c < 32; c++)
      for (int r = 0; r < 15; r++) begin
        if (k < limit) push_write(r * 32 + c, level_mem[c * 16 + r]);
        k++;
      end
  endfunction

  function automatic void apply_tick(input int sp);
    int nw, ring;
    nw = (m_off + sp) % 1024;
    if ((nw / 32) != (m_off / 32)) begin
      ring = (nw / 32 + 31) % 32;
      for (int r = 0; r < 15; r++)
        push_write(r * 32 + ring, (m_next < LEVEL_COLS) ? level_mem[m_next * 16 + r] : 8'h00);
      if (m_next >= LEVEL_COLS) m_level_end = 1;
      m_next++;
    end
    m_off = nw;
  endfunction

  task automatic wait_quiet();
    int idle_run, n;
    idle_run = 0;
    n = 0;
    while (idle_run < 3 && n < 500) begin
      @(negedge mem_clk);
      if (busy) idle_run = 0;
      else idle_run++;
      n++;
    end
    n_tests++;
    if (idle_run < 3) begin
      n_fail++;
      $display("FAIL quiet_timeout: busy still %b after %0d cycles, expected 0", busy, n);
    end
    @(posedge mem_clk); #1;
  endtask

  task automatic do_tick(input int sp);
    speed = 5'(sp);
    frame_tick = 1'b1;
    apply_tick(sp);
    @(posedge mem_clk); #1;
    frame_tick = 1'b0;
    wait_quiet();
    check("scroll_offset", 32'(scroll_offset), 32'(m_off));
  endtask

  task automatic host_xact(input logic we, input logic [13:0] a, input logic [7:0] d, output int waited);
    int n;
    if (we) push_write(int'(a), d);
    host_we = we; host_addr = a; host_din = d; host_req = 1'b1;
    n = 0;
    @(negedge mem_clk);
    while (host_ack !== 1'b1 && n < 300) begin
      @(negedge mem_clk);
      n++;
    end
    check("host_ack_seen", 32'(host_ack), 32'd1);
    waited = n;
    @(posedge mem_clk); #1;
    host_req = 1'b0;
    if (!we) begin
      @(posedge mem_clk); #1;
      check("host_rdata", 32'(host_rdata), 32'(tm_model[a]));
    end
  endtask

  task automatic make_crossable();
    if (m_off % 32 == 0) do_tick(1);
  endtask

  task automatic abort_preload(input bit use_reset);
    int w0;
    model_start();
    push_preload(100);
    w0 = wr_count;
    start = 1'b1;
    @(posedge mem_clk); #1;
    start = 1'b0;
    repeat (100) @(posedge mem_clk);
    #1;
    if (use_reset) mem_reset_n = 1'b0;
    else stop = 1'b1;
    @(posedge mem_clk); #1;
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge mem_clk);
      check("abort_tm_we", 32'(tm_we), 32'd0);
    end
    check("abort_running", 32'(running), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_writes", 32'(wr_count - w0), 32'd100);
    if (use_reset) begin
      check("reset_offset", 32'(scroll_offset), 32'd0);
      check("reset_tm_address", 32'(tm_address), 32'd0);
      check("reset_level_addr", 32'(level_addr), 32'd0);
      @(posedge mem_clk); #1;
      mem_reset_n = 1'b1;
    end
    @(posedge mem_clk); #1;
  endtask

  initial begin
    int n, w0, waited, sp, d;
    logic [13:0] ha;
    logic [7:0]  hd;

    for (int i = 0; i < 16384; i++) begin
      level_mem[i] = 8'($urandom);
      tm_mem[i]    = 8'd0;
      tm_model[i]  = 8'd0;
    end
    mem_reset_n = 1'b0;
    start = 0; stop = 0; frame_tick = 0; speed = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_din = 0;
    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk);
    check("rst_scroll_offset", 32'(scroll_offset), 32'd0);
    check("rst_tm_we", 32'(tm_we), 32'd0);
    check("rst_tm_address", 32'(tm_address), 32'd0);
    check("rst_tm_din", 32'(tm_din), 32'd0);
    check("rst_level_addr", 32'(level_addr), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    check("rst_host_ack", 32'(host_ack), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level_end", 32'(level_end), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(posedge mem_clk); #1;
    mem_reset_n = 1'b1;
    @(posedge mem_clk); #1;

    // Host write then read back while IDLE.
    ha = 14'h2A5C;
    hd = 8'($urandom);
    host_xact(1'b1, ha, hd, waited);
    host_xact(1'b0, ha, 8'd0, waited);

    // start together with stop stays IDLE.
    start = 1'b1; stop = 1'b1;
    @(posedge mem_clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge mem_clk);
    check("start_stop_idle", 32'(running), 32'd0);
    @(posedge mem_clk); #1;

    // Preload: 480 writes over 481 busy cycles.
    model_start();
    push_preload(480);
    w0 = wr_count;
    start = 1'b1;
    @(posedge mem_clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge mem_clk);
      if (busy) n++;
      else break;
    end
    check("preload_cycles", 32'(n), 32'd481);
    check("preload_writes", 32'(wr_count - w0), 32'd480);
    check("preload_offset", 32'(scroll_offset), 32'd0);
    check("preload_running", 32'(running), 32'd1);
    check("preload_level_end", 32'(level_end), 32'd0);
    @(posedge mem_clk); #1;

    // start in RUN is ignored.
    start = 1'b1;
    @(posedge mem_clk); #1;
    start = 1'b0;
    @(negedge mem_clk);
    check("start_in_run_busy", 32'(busy), 32'd0);
    @(posedge mem_clk); #1;

    // Crossing: 0 -> 28 -> 33 refills ring column 0 with level column 32.
    w0 = wr_count;
    do_tick(28);
    check("no_cross_writes", 32'(wr_count - w0), 32'd0);
    do_tick(5);
    check("cross_offset", 32'(scroll_offset), 32'd33);
    check("cross_writes", 32'(wr_count - w0), 32'd15);
    check("cross_last", 32'(last_wr), 32'({5'b0, 4'd14, 5'd0, level_mem[32 * 16 + 14]}));

    // Tick coincident with host request: tick wins this cycle.
    speed = 5'd0;
    frame_tick = 1'b1;
    apply_tick(0);
    host_we = 1'b0; host_addr = 14'd37; host_req = 1'b1;
    @(negedge mem_clk);
    check("tick_over_host", 32'(host_ack), 32'd0);
    @(posedge mem_clk); #1;
    frame_tick = 1'b0;
    host_xact(1'b0, 14'd37, 8'd0, waited);
    wait_quiet();

    // Host read held during REFILL is granted only afterwards.
    make_crossable();
    speed = 5'd31;
    frame_tick = 1'b1;
    apply_tick(31);
    @(posedge mem_clk); #1;
    frame_tick = 1'b0;
    host_xact(1'b0, 14'(5 * 32 + (m_off / 32 + 31) % 32), 8'd0, waited);
    check("host_waited_refill", 32'(waited >= 14), 32'd1);
    wait_quiet();

    // Two ticks during REFILL: one held, one dropped.
    make_crossable();
    check("overrun_before", 32'(overrun), 32'd0);
    speed = 5'd31;
    frame_tick = 1'b1;
    apply_tick(31);
    @(posedge mem_clk); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge mem_clk);
    #1 frame_tick = 1'b1;
    apply_tick(31);
    @(posedge mem_clk); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge mem_clk);
    #1 frame_tick = 1'b1;
    @(posedge mem_clk); #1;
    frame_tick = 1'b0;
    wait_quiet();
    check("overrun_after", 32'(overrun), 32'd1);
    check("pending_offset", 32'(scroll_offset), 32'(m_off));

    // Randomized ticks and host reads.
    for (int i = 0; i < 25; i++) begin
      do_tick(int'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0)
        host_xact(1'b0, 14'($urandom_range(0, 479)), 8'd0, waited);
      repeat ($urandom_range(0, 3)) @(posedge mem_clk);
      #1;
    end

    // Walk to 1020, then wrap past 1023.
    while (m_off != 1020) begin
      d = (1020 - m_off + 1024) % 1024;
      sp = (d > 31) ? 31 : d;
      do_tick(sp);
    end
    do_tick(8);
    check("wrap_offset", 32'(scroll_offset), 32'd4);
    check("wrap_ring_col", 32'(last_wr[12:8]), 32'd31);
    check("level_end_model", 32'(level_end), 32'(m_level_end));
    check("level_end_set", 32'(level_end), 32'd1);

    // stop from RUN holds the offset.
    stop = 1'b1;
    @(posedge mem_clk); #1;
    stop = 1'b0;
    @(negedge mem_clk);
    check("stop_running", 32'(running), 32'd0);
    check("stop_offset_held", 32'(scroll_offset), 32'(m_off));
    @(posedge mem_clk); #1;

    abort_preload(1'b0);
    abort_preload(1'b1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
